// File: rtl/trigger_link_startup_ctrl.sv
// Bring-up and recovery sequencer for the trigger TX links: drives the shared PLL
// reset and per-link TX resets, waits for lock/reset-done with timeouts, and retries.
module trigger_link_startup_ctrl #(
  parameter int NLINKS         = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int TX_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT   = 4000,
  parameter int DONE_TIMEOUT   = 4000,
  parameter int MAX_RETRIES    = 7
) (
  input  logic              clk_40,
  input  logic              reset_i,
  input  logic              restart,
  input  logic [NLINKS-1:0] link_mask,
  input  logic [NLINKS-1:0] pll_locked,
  input  logic [NLINKS-1:0] reset_done,
  output logic              pll_reset,
  output logic [NLINKS-1:0] tx_reset,
  output logic              links_ready,
  output logic              fault,
  output logic [3:0]        retry_cnt,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_TX_RST    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_READY     = 3'd5,
    ST_RETRY     = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  localparam logic [15:0] PLL_RST_LAST = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] TX_RST_LAST  = 16'(TX_RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] DONE_LAST    = 16'(DONE_TIMEOUT - 1);
  localparam logic [3:0]  MAX_RETRY_C  = 4'(MAX_RETRIES);

  state_t            state_r;
  state_t            next_state_s;
  logic [15:0]       timer_r;
  logic [3:0]        retry_cnt_r;
  logic [3:0]        retry_inc_s;
  logic [NLINKS-1:0] pll_locked_meta_r;
  logic [NLINKS-1:0] pll_locked_sync_r;
  logic [NLINKS-1:0] reset_done_meta_r;
  logic [NLINKS-1:0] reset_done_sync_r;
  logic              all_locked_s;
  logic              all_done_s;
  logic              pll_reset_r;
  logic [NLINKS-1:0] tx_reset_r;
  logic              links_ready_r;
  logic              fault_r;
  logic              pll_reset_nxt_s;
  logic [NLINKS-1:0] tx_reset_nxt_s;
  logic              links_ready_nxt_s;
  logic              fault_nxt_s;

  // Two-flop synchronizers for the asynchronous transceiver status inputs.
  always_ff @(posedge clk_40) begin
    if (reset_i) begin
      pll_locked_meta_r <= {NLINKS{1'b0}};
      pll_locked_sync_r <= {NLINKS{1'b0}};
      reset_done_meta_r <= {NLINKS{1'b0}};
      reset_done_sync_r <= {NLINKS{1'b0}};
    end else begin
      pll_locked_meta_r <= pll_locked;
      pll_locked_sync_r <= pll_locked_meta_r;
      reset_done_meta_r <= reset_done;
      reset_done_sync_r <= reset_done_meta_r;
    end
  end

  // Masked links count as locked/done, so an empty mask is trivially all-true.
  assign all_locked_s = &(pll_locked_sync_r | ~link_mask);
  assign all_done_s   = &(reset_done_sync_r | ~link_mask);
  assign retry_inc_s  = (retry_cnt_r == 4'd15) ? 4'd15 : (retry_cnt_r + 4'd1);

  // State register.
  always_ff @(posedge clk_40) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; restart overrides every other transition.
  always_comb begin
    next_state_s = state_r;
    if (restart) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_state_s = ST_PLL_RST;
        end
        ST_PLL_RST: begin
          if (timer_r == PLL_RST_LAST) begin
            next_state_s = ST_WAIT_LOCK;
          end else begin
            next_state_s = ST_PLL_RST;
          end
        end
        ST_WAIT_LOCK: begin
          if (all_locked_s) begin
            next_state_s = ST_TX_RST;
          end else if (timer_r == LOCK_LAST) begin
            next_state_s = ST_RETRY;
          end else begin
            next_state_s = ST_WAIT_LOCK;
          end
        end
        ST_TX_RST: begin
          if (timer_r == TX_RST_LAST) begin
            next_state_s = ST_WAIT_DONE;
          end else begin
            next_state_s = ST_TX_RST;
          end
        end
        ST_WAIT_DONE: begin
          if (!all_locked_s) begin
            next_state_s = ST_RETRY;
          end else if (all_done_s) begin
            next_state_s = ST_READY;
          end else if (timer_r == DONE_LAST) begin
            next_state_s = ST_RETRY;
          end else begin
            next_state_s = ST_WAIT_DONE;
          end
        end
        ST_READY: begin
          if (!all_locked_s || !all_done_s) begin
            next_state_s = ST_RETRY;
          end else begin
            next_state_s = ST_READY;
          end
        end
        ST_RETRY: begin
          if (retry_inc_s == MAX_RETRY_C) begin
            next_state_s = ST_FAULT;
          end else begin
            next_state_s = ST_PLL_RST;
          end
        end
        ST_FAULT: begin
          next_state_s = ST_FAULT;
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State timer: cleared on every state entry, saturates rather than wrapping.
  always_ff @(posedge clk_40) begin
    if (reset_i) begin
      timer_r <= 16'd0;
    end else if (restart || (next_state_s != state_r)) begin
      timer_r <= 16'd0;
    end else if (timer_r != 16'hFFFF) begin
      timer_r <= timer_r + 16'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Failed-attempt counter, bumped once per pass through RETRY.
  always_ff @(posedge clk_40) begin
    if (reset_i || restart) begin
      retry_cnt_r <= 4'd0;
    end else if (state_r == ST_RETRY) begin
      retry_cnt_r <= retry_inc_s;
    end else begin
      retry_cnt_r <= retry_cnt_r;
    end
  end

  // Output decode from the current state; registered one cycle later below.
  always_comb begin
    pll_reset_nxt_s   = 1'b1;
    tx_reset_nxt_s    = {NLINKS{1'b1}};
    links_ready_nxt_s = 1'b0;
    fault_nxt_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_PLL_RST: begin
        pll_reset_nxt_s = 1'b1;
      end
      ST_WAIT_LOCK, ST_TX_RST, ST_RETRY: begin
        pll_reset_nxt_s = 1'b0;
      end
      ST_WAIT_DONE: begin
        pll_reset_nxt_s = 1'b0;
        tx_reset_nxt_s  = ~link_mask;
      end
      ST_READY: begin
        pll_reset_nxt_s   = 1'b0;
        tx_reset_nxt_s    = ~link_mask;
        links_ready_nxt_s = 1'b1;
      end
      ST_FAULT: begin
        fault_nxt_s = 1'b1;
      end
      default: begin
        pll_reset_nxt_s = 1'b1;
      end
    endcase
  end

  // Output registers; restart returns them to their idle values immediately.
  always_ff @(posedge clk_40) begin
    if (reset_i || restart) begin
      pll_reset_r   <= 1'b1;
      tx_reset_r    <= {NLINKS{1'b1}};
      links_ready_r <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      pll_reset_r   <= pll_reset_nxt_s;
      tx_reset_r    <= tx_reset_nxt_s;
      links_ready_r <= links_ready_nxt_s;
      fault_r       <= fault_nxt_s;
    end
  end

  assign pll_reset   = pll_reset_r;
  assign tx_reset    = tx_reset_r;
  assign links_ready = links_ready_r;
  assign fault       = fault_r;
  assign retry_cnt   = retry_cnt_r;
  assign state       = state_r;

endmodule

// File: tb/tb_trigger_link_startup_ctrl.sv
// Directed bench for trigger_link_startup_ctrl: nominal bring-up, retries,
// masking, restart/reset priority, timeouts and the FAULT state.
module tb_trigger_link_startup_ctrl;

  logic       clk_40 = 1'b0;
  logic       reset_i = 1'b1;
  logic       restart = 1'b0;
  logic [3:0] link_mask = 4'hF;
  logic [3:0] pll_locked = 4'h0;
  logic [3:0] reset_done = 4'h0;
  logic       pll_reset;
  logic [3:0] tx_reset;
  logic       links_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int n;

  trigger_link_startup_ctrl dut (
    .clk_40      (clk_40),
    .reset_i     (reset_i),
    .restart     (restart),
    .link_mask   (link_mask),
    .pll_locked  (pll_locked),
    .reset_done  (reset_done),
    .pll_reset   (pll_reset),
    .tx_reset    (tx_reset),
    .links_ready (links_ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  always #5 clk_40 = ~clk_40;

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_40);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until the FSM shows state s; an expired budget fails the state check.
  task automatic wait_state(input logic [2:0] s, input int max, input string tag, output int cnt);
    cnt = 0;
    while (state !== s && cnt < max) begin
      step(1);
      cnt++;
    end
    chk(tag, state, s);
  endtask

  task automatic count_state(input logic [2:0] s, input int max, output int cnt);
    cnt = 0;
    while (state === s && cnt < max) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  initial begin
    // Reset values
    step(3);
    chk("rst_state", state, 3'd0);
    chk("rst_pll_reset", pll_reset, 1'b1);
    chk("rst_tx_reset", tx_reset, 4'hF);
    chk("rst_links_ready", links_ready, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_retry_cnt", retry_cnt, 4'd0);

    // Nominal bring-up
    reset_i = 1'b0;
    step(1);
    chk("nom_enter_pll_rst", state, 3'd1);
    count_state(3'd1, 100, n);
    chk("nom_pll_rst_cycles", n, 16);
    chk("nom_state_wait_lock", state, 3'd2);
    chk("nom_pll_reset_lag", pll_reset, 1'b1);
    step(1);
    chk("nom_pll_reset_fall", pll_reset, 1'b0);
    step(99);
    chk("nom_still_wait_lock", state, 3'd2);
    pll_locked = 4'hF;
    wait_state(3'd3, 10, "nom_reach_tx_rst", n);
    chk("nom_lock_latency", n, 3);
    count_state(3'd3, 100, n);
    chk("nom_tx_rst_cycles", n, 16);
    chk("nom_state_wait_done", state, 3'd4);
    step(1);
    chk("nom_tx_reset_fall", tx_reset, 4'h0);
    step(49);
    reset_done = 4'hF;
    wait_state(3'd5, 10, "nom_reach_ready", n);
    chk("nom_done_latency", n, 3);
    step(1);
    chk("nom_links_ready", links_ready, 1'b1);
    chk("nom_retry_cnt", retry_cnt, 4'd0);

    // One-cycle loss of lock on link 1 while READY
    pll_locked = 4'b1101;
    step(1);
    pll_locked = 4'hF;
    n = 1;
    while (links_ready === 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("lol_ready_fall_cycles", n, 4);
    chk("lol_state_pll_rst", state, 3'd1);
    chk("lol_retry_cnt", retry_cnt, 4'd1);
    n = 0;
    step(1);
    while (pll_reset === 1'b1 && n < 50) begin
      n++;
      step(1);
    end
    chk("lol_pll_reset_high_cycles", n, 16);
    wait_state(3'd5, 200, "lol_back_to_ready", n);
    step(1);
    chk("lol_links_ready_again", links_ready, 1'b1);

    // Clearing a mask bit in READY is not a failure, and the dead link is ignored
    link_mask = 4'b0111;
    step(1);
    chk("mclr_tx_reset", tx_reset, 4'b1000);
    pll_locked = 4'b0111;
    reset_done = 4'b0111;
    step(5);
    chk("mclr_state_ready", state, 3'd5);
    chk("mclr_retry_cnt", retry_cnt, 4'd1);

    // Restart from READY, then sequence with link 3 masked and never locking
    pulse_restart();
    chk("rs_state_idle", state, 3'd0);
    chk("rs_retry_cnt", retry_cnt, 4'd0);
    chk("rs_links_ready", links_ready, 1'b0);
    chk("rs_pll_reset", pll_reset, 1'b1);
    wait_state(3'd5, 200, "mask_reach_ready", n);
    step(1);
    chk("mask_links_ready", links_ready, 1'b1);
    chk("mask_tx_reset", tx_reset, 4'b1000);

    // Setting a mask bit for a link that is not up forces a retry
    link_mask = 4'hF;
    wait_state(3'd6, 5, "mset_retry", n);
    chk("mset_retry_latency", n, 1);
    step(1);
    chk("mset_state_pll_rst", state, 3'd1);
    chk("mset_retry_cnt", retry_cnt, 4'd1);
    link_mask = 4'b0111;
    wait_state(3'd5, 200, "mset_back_to_ready", n);

    // Restart in the middle of WAIT_DONE
    reset_done = 4'h0;
    pulse_restart();
    wait_state(3'd4, 200, "rwd_reach_wait_done", n);
    step(5);
    chk("rwd_still_wait_done", state, 3'd4);
    pulse_restart();
    chk("rwd_state_idle", state, 3'd0);
    chk("rwd_retry_cnt", retry_cnt, 4'd0);
    chk("rwd_fault", fault, 1'b0);

    // Partial reset-done: timeout, then READY once all four are done
    link_mask = 4'hF;
    pll_locked = 4'hF;
    reset_done = 4'b1011;
    pulse_restart();
    wait_state(3'd4, 200, "pd_reach_wait_done", n);
    count_state(3'd4, 5000, n);
    chk("pd_wait_done_cycles", n, 4000);
    chk("pd_state_retry", state, 3'd6);
    step(1);
    chk("pd_state_pll_rst", state, 3'd1);
    chk("pd_retry_cnt", retry_cnt, 4'd1);
    reset_done = 4'hF;
    wait_state(3'd5, 200, "pd_reach_ready", n);
    step(1);
    chk("pd_links_ready", links_ready, 1'b1);

    // reset_i together with restart gives the reset values
    reset_i = 1'b1;
    restart = 1'b1;
    step(1);
    chk("rr_state", state, 3'd0);
    chk("rr_retry_cnt", retry_cnt, 4'd0);
    chk("rr_links_ready", links_ready, 1'b0);
    chk("rr_pll_reset", pll_reset, 1'b1);
    chk("rr_tx_reset", tx_reset, 4'hF);
    restart = 1'b0;
    pll_locked = 4'h0;
    reset_done = 4'h0;
    step(1);
    reset_i = 1'b0;

    // Lock timeout: seven failed attempts end in FAULT
    wait_state(3'd6, 5000, "lt_first_retry", n);
    chk("lt_retry_cnt_1", retry_cnt, 4'd0);
    for (int i = 2; i <= 7; i++) begin
      step(1);
      wait_state(3'd6, 5000, "lt_next_retry", n);
      chk("lt_retry_period", n + 1, 4017);
      chk("lt_retry_cnt", retry_cnt, i - 1);
    end
    step(1);
    chk("lt_state_fault", state, 3'd7);
    chk("lt_retry_cnt_final", retry_cnt, 4'd7);
    step(1);
    chk("lt_fault", fault, 1'b1);
    chk("lt_pll_reset", pll_reset, 1'b1);
    chk("lt_tx_reset", tx_reset, 4'hF);
    chk("lt_links_ready", links_ready, 1'b0);
    pll_locked = 4'hF;
    reset_done = 4'hF;
    step(100);
    chk("lt_fault_sticky_state", state, 3'd7);
    chk("lt_fault_sticky", fault, 1'b1);
    pulse_restart();
    chk("lt_restart_state", state, 3'd0);
    chk("lt_restart_fault", fault, 1'b0);
    chk("lt_restart_retry_cnt", retry_cnt, 4'd0);
    wait_state(3'd5, 200, "lt_recover_ready", n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
